// File: rtl/vrased_rst_seq_pkg.sv
// Shared types and constants for the VRASED reset sequencer.
package vrased_rst_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE    = 2'd0,
    SEQ_ASSERT  = 2'd1,
    SEQ_RELEASE = 2'd2
  } seq_state_e;

  localparam logic [15:0] RESET_HANDLER_DEF = 16'h0000;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vrased_rst_seq_if.sv
// Monitor-side bundle of the reset sequencer: violation inputs and reset/log outputs.
interface vrased_rst_seq_if #(parameter int CNT_W = 8);
  logic             viol_req;
  logic             swatt_exec;
  logic [15:0]      pc;
  logic             cpu_rst;
  logic             seq_busy;
  logic             attest_abort;
  logic [CNT_W-1:0] viol_cnt;
  logic [15:0]      viol_pc;

  modport master (
    output viol_req, swatt_exec, pc,
    input  cpu_rst, seq_busy, attest_abort, viol_cnt, viol_pc
  );

  modport slave (
    input  viol_req, swatt_exec, pc,
    output cpu_rst, seq_busy, attest_abort, viol_cnt, viol_pc
  );
endinterface

// File: rtl/vrased_rst_seq_down_cnt.sv
// Loadable down-counter that stops at zero; load has priority over decrement.
module vrased_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/vrased_rst_seq.sv
// VRASED reset sequencer: stretched CPU reset, re-entry check at RESET_HANDLER.
// Violation logging is built only when VRASED_VIOL_LOG_EN is defined.
module vrased_rst_seq
  import vrased_rst_seq_pkg::*;
#(
  parameter logic [15:0] RESET_HANDLER = RESET_HANDLER_DEF,
  parameter int          HOLD_CYCLES   = 4,
  parameter int          FETCH_TIMEOUT = 16,
  parameter int          CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  vrased_rst_seq_if.slave  bus
);
  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam int TW = cnt_w(FETCH_TIMEOUT);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TOUT_LD = TW'(FETCH_TIMEOUT - 1);

  seq_state_e r_state;
  logic       r_cpu_rst;
  logic       r_busy;
  logic       w_hold_zero, w_tout_zero;
  logic       w_accept, w_timeout, w_pc_hit, w_release;

  always_comb begin
    w_pc_hit  = (bus.pc == RESET_HANDLER);
    w_accept  = bus.viol_req && (r_state == SEQ_IDLE || r_state == SEQ_RELEASE);
    w_timeout = (r_state == SEQ_RELEASE) && !bus.viol_req && !w_pc_hit && w_tout_zero;
    w_release = (r_state == SEQ_ASSERT) && w_hold_zero && !bus.viol_req;
  end

  vrased_down_cnt #(.W(HW)) u_hold_cnt (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_load     (w_accept || w_timeout),
    .i_load_val (HOLD_LD),
    .i_dec      (r_state == SEQ_ASSERT),
    .o_zero     (w_hold_zero)
  );

  vrased_down_cnt #(.W(TW)) u_tout_cnt (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_load     (w_release),
    .i_load_val (TOUT_LD),
    .i_dec      (r_state == SEQ_RELEASE),
    .o_zero     (w_tout_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= SEQ_IDLE;
      r_cpu_rst <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        SEQ_IDLE: begin
          if (w_accept) begin
            r_state   <= SEQ_ASSERT;
            r_cpu_rst <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        SEQ_ASSERT: begin
          if (w_release) begin
            r_state   <= SEQ_RELEASE;
            r_cpu_rst <= 1'b0;
          end
        end
        SEQ_RELEASE: begin
          // A violation outranks the PC match; timeout re-resets without logging.
          if (w_accept || w_timeout) begin
            r_state   <= SEQ_ASSERT;
            r_cpu_rst <= 1'b1;
          end else if (w_pc_hit) begin
            r_state <= SEQ_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state   <= SEQ_IDLE;
          r_cpu_rst <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_rst  = r_cpu_rst;
  assign bus.seq_busy = r_busy;

`ifdef VRASED_VIOL_LOG_EN
  logic             r_attest_abort;
  logic [CNT_W-1:0] r_viol_cnt;
  logic [15:0]      r_viol_pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_attest_abort <= 1'b0;
      r_viol_cnt     <= '0;
      r_viol_pc      <= '0;
    end else if (w_accept) begin
      if (r_viol_cnt != '1) r_viol_cnt <= r_viol_cnt + CNT_W'(1);
      r_viol_pc <= bus.pc;
      if (bus.swatt_exec) r_attest_abort <= 1'b1;
    end
  end

  assign bus.attest_abort = r_attest_abort;
  assign bus.viol_cnt     = r_viol_cnt;
  assign bus.viol_pc      = r_viol_pc;
`else
  logic w_unused_swatt;
  assign w_unused_swatt   = bus.swatt_exec;
  assign bus.attest_abort = 1'b0;
  assign bus.viol_cnt     = '0;
  assign bus.viol_pc      = '0;
`endif
endmodule

// File: tb/tb_vrased_rst_seq.sv
// Bench for vrased_rst_seq: cycle table with scoreboard plus hand-written corner sequences.
module tb_vrased_rst_seq;
`ifdef VRASED_VIOL_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vrased_rst_seq_if #(.CNT_W(8)) b1 ();
  vrased_rst_seq_if #(.CNT_W(8)) b2 ();

  vrased_rst_seq #(
    .RESET_HANDLER (16'h0000),
    .HOLD_CYCLES   (4),
    .FETCH_TIMEOUT (16),
    .CNT_W         (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b1)
  );

  vrased_rst_seq #(
    .RESET_HANDLER (16'h4400),
    .HOLD_CYCLES   (1),
    .FETCH_TIMEOUT (1),
    .CNT_W         (8)
  ) dut_min (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b2)
  );

  typedef struct {
    int          rep;
    logic        viol;
    logic        swatt;
    logic [15:0] pc;
    logic        exp_rst;
    logic        exp_busy;
  } vec_t;

  typedef struct {
    logic rst;
    logic busy;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive1(input logic v, input logic s, input logic [15:0] p);
    b1.viol_req = v; b1.swatt_exec = s; b1.pc = p;
  endtask

  task automatic apply(input logic v, input logic s, input logic [15:0] p,
                       input logic er, input logic eb, input string name);
    exp_t e;
    @(negedge clk);
    drive1(v, s, p);
    sb.push_back('{rst: er, busy: eb});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({name, ".rst_busy"}, {30'd0, b1.cpu_rst, b1.seq_busy}, {30'd0, e.rst, e.busy});
  endtask

  task automatic apply2(input logic v, input logic [15:0] p,
                        input logic er, input logic eb, input string name);
    @(negedge clk);
    b2.viol_req = v; b2.pc = p;
    @(posedge clk);
    #1;
    chk({name, ".rst_busy"}, {30'd0, b2.cpu_rst, b2.seq_busy}, {30'd0, er, eb});
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    @(negedge clk);
    drive1(1'b0, 1'b0, 16'h0000);
    while (b1.seq_busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, ".idle_wait"}, {31'd0, b1.seq_busy}, 32'd0);
  endtask

  task automatic chk_logs(input string name, input logic ab, input logic [7:0] cnt,
                          input logic [15:0] vpc);
    chk({name, ".attest_abort"}, {31'd0, b1.attest_abort}, {31'd0, LOG & ab});
    chk({name, ".viol_cnt"},     {24'd0, b1.viol_cnt},     {24'd0, LOG ? cnt : 8'h00});
    chk({name, ".viol_pc"},      {16'd0, b1.viol_pc},      {16'd0, LOG ? vpc : 16'h0000});
  endtask

  initial begin
    // rep, viol, swatt, pc, cpu_rst, busy
    tbl[0]  = '{1,  1'b0, 1'b0, 16'hE000, 1'b0, 1'b0};
    tbl[1]  = '{1,  1'b1, 1'b0, 16'hE000, 1'b1, 1'b1};
    tbl[2]  = '{3,  1'b0, 1'b0, 16'hE000, 1'b1, 1'b1};
    tbl[3]  = '{2,  1'b0, 1'b0, 16'hE000, 1'b0, 1'b1};
    tbl[4]  = '{1,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[5]  = '{10, 1'b1, 1'b0, 16'hE000, 1'b1, 1'b1};
    tbl[6]  = '{1,  1'b0, 1'b0, 16'hE000, 1'b0, 1'b1};
    tbl[7]  = '{15, 1'b0, 1'b0, 16'hE000, 1'b0, 1'b1};
    tbl[8]  = '{1,  1'b0, 1'b0, 16'hE000, 1'b1, 1'b1};
    tbl[9]  = '{3,  1'b0, 1'b0, 16'hE000, 1'b1, 1'b1};
    tbl[10] = '{1,  1'b0, 1'b0, 16'hE000, 1'b0, 1'b1};
    tbl[11] = '{1,  1'b1, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[12] = '{3,  1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[13] = '{1,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[14] = '{1,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[15] = '{1,  1'b1, 1'b0, 16'h1234, 1'b1, 1'b1};
    tbl[16] = '{2,  1'b0, 1'b0, 16'h1234, 1'b1, 1'b1};
    tbl[17] = '{2,  1'b1, 1'b0, 16'h5555, 1'b1, 1'b1};
    tbl[18] = '{1,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[19] = '{1,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

    drive1(1'b0, 1'b0, 16'hE000);
    b2.viol_req = 1'b0; b2.swatt_exec = 1'b0; b2.pc = 16'h4400;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.cpu_rst", {31'd0, b1.cpu_rst}, 32'd0);
    chk("reset.busy",    {31'd0, b1.seq_busy}, 32'd0);
    chk_logs("reset", 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        apply(tbl[i].viol, tbl[i].swatt, tbl[i].pc, tbl[i].exp_rst, tbl[i].exp_busy,
              $sformatf("tbl%0d", i));
      end
    end
    chk_logs("table", 1'b0, 8'd4, 16'h1234);

    apply(1'b1, 1'b1, 16'hA010, 1'b1, 1'b1, "swatt_viol");
    chk_logs("swatt_viol", 1'b1, 8'd5, 16'hA010);
    wait_idle("swatt_viol");
    apply(1'b1, 1'b0, 16'h0BAD, 1'b1, 1'b1, "sticky_viol");
    chk_logs("sticky_viol", 1'b1, 8'd6, 16'h0BAD);
    wait_idle("sticky_viol");

    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      drive1(1'b1, 1'b0, 16'h0300);
      wait_idle($sformatf("sat%0d", j));
    end
    chk_logs("saturate", 1'b1, 8'hFF, 16'h0300);

    apply(1'b1, 1'b0, 16'h0777, 1'b1, 1'b1, "async_pre");
    #2;
    reset_n = 1'b0;
    #1;
    chk("async.cpu_rst", {31'd0, b1.cpu_rst}, 32'd0);
    chk("async.busy",    {31'd0, b1.seq_busy}, 32'd0);
    chk_logs("async", 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    drive1(1'b0, 1'b0, 16'hE000);
    reset_n = 1'b1;
    apply(1'b0, 1'b0, 16'hE000, 1'b0, 1'b0, "async_post");

    b2.pc = 16'h0000;
    apply2(1'b1, 16'h0000, 1'b1, 1'b1, "min_pulse");
    apply2(1'b0, 16'h0000, 1'b0, 1'b1, "min_release");
    apply2(1'b0, 16'h0000, 1'b1, 1'b1, "min_timeout");
    apply2(1'b0, 16'h0000, 1'b0, 1'b1, "min_release2");
    apply2(1'b0, 16'h4400, 1'b0, 1'b0, "min_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
